// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full_adder cell is stepped LSB-first over WIDTH bits,
// with valid/ready handshakes on the operand side and the result side.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START_VALID,
  output logic             START_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_IN,
  output logic [WIDTH-1:0] SUM,
  output logic             CARRY,
  output logic             DONE_VALID,
  input  logic             DONE_READY
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-1:0] psum_r;
  logic [WIDTH-1:0] psum_next_s;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic             cout_r;
  logic [CNT_W-1:0] cnt_r;
  logic             fa_sum_s;
  logic             fa_carry_s;
  logic             last_bit_s;

  full_adder u_fa (
    .A     (a_sr_r[0]),
    .B     (b_sr_r[0]),
    .C_IN  (carry_r),
    .SUM   (fa_sum_s),
    .CARRY (fa_carry_s)
  );

  assign last_bit_s  = (cnt_r == LAST_CNT);
  assign START_READY = (state_r == IDLE);
  assign DONE_VALID  = (state_r == DONE);
  assign SUM         = sum_r;
  assign CARRY       = cout_r;

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (START_VALID) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (last_bit_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE: begin
        if (DONE_READY) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Partial sum after this cycle's bit: shift right, new bit enters at the MSB
  always_comb begin
    psum_next_s            = psum_r >> 1;
    psum_next_s[WIDTH-1]   = fa_sum_s;
  end

  // Operand, carry, counter and result registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      a_sr_r  <= {WIDTH{1'b0}};
      b_sr_r  <= {WIDTH{1'b0}};
      psum_r  <= {WIDTH{1'b0}};
      sum_r   <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (START_VALID) begin
            a_sr_r  <= A;
            b_sr_r  <= B;
            carry_r <= C_IN;
            cnt_r   <= {CNT_W{1'b0}};
          end
        end
        RUN: begin
          a_sr_r  <= a_sr_r >> 1;
          b_sr_r  <= b_sr_r >> 1;
          carry_r <= fa_carry_s;
          psum_r  <= psum_next_s;
          cnt_r   <= cnt_r + CNT_ONE;
          // The result must include the bit computed on this final edge
          if (last_bit_s) begin
            sum_r  <= psum_next_s;
            cout_r <= fa_carry_s;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end
endmodule

module full_adder (
  input  logic A,
  input  logic B,
  input  logic C_IN,
  output logic SUM,
  output logic CARRY
);
  assign SUM   = A ^ B ^ C_IN;
  assign CARRY = (A & B) | (C_IN & (A ^ B));
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: scoreboard of expected {CARRY,SUM} pushed at
// accept and popped at the result handshake; WIDTH=8 and WIDTH=1 instances.
module tb_serial_add_ctrl;
  logic       clk = 1'b0;
  logic       clk_run = 1'b0;
  logic       rst = 1'b0;
  logic       start_valid = 1'b0;
  logic       start_ready;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       c_in = 1'b0;
  logic [7:0] sum;
  logic       carry;
  logic       done_valid;
  logic       done_ready = 1'b0;

  logic       sv1 = 1'b0;
  logic       sr1;
  logic [0:0] a1 = 1'b0;
  logic [0:0] b1 = 1'b0;
  logic       c1 = 1'b0;
  logic [0:0] sum1;
  logic       carry1;
  logic       dv1;
  logic       dr1 = 1'b0;

  logic [8:0] sb[$];
  logic [1:0] sb1[$];
  logic [8:0] last_exp = 9'h000;
  int         n_cmp = 0;
  int         n_err = 0;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .CLK(clk), .RESET(rst), .START_VALID(start_valid), .START_READY(start_ready),
    .A(a), .B(b), .C_IN(c_in), .SUM(sum), .CARRY(carry),
    .DONE_VALID(done_valid), .DONE_READY(done_ready)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .CLK(clk), .RESET(rst), .START_VALID(sv1), .START_READY(sr1),
    .A(a1), .B(b1), .C_IN(c1), .SUM(sum1), .CARRY(carry1),
    .DONE_VALID(dv1), .DONE_READY(dr1)
  );

  always #5 if (clk_run) clk = ~clk;

  // Drives one operation from IDLE (called at #1 after an edge), returns observed latency/result
  task automatic drive_op(input logic [7:0] oa, input logic [7:0] ob, input logic oc,
                          output int lat, output logic [7:0] s, output logic c);
    a = oa; b = ob; c_in = oc; start_valid = 1'b1; done_ready = 1'b0;
    sb.push_back({1'b0, oa} + {1'b0, ob} + {8'h00, oc});
    @(posedge clk); #1;
    start_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); c_in = 1'($urandom);
    lat = 999;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done_valid) begin
        lat = i;
        break;
      end
    end
    s = sum; c = carry;
    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    n_cmp++;
    if ({carry, sum, done_valid, start_ready, sr1, dv1} !== {1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL reset_values: got carry=%b sum=%h dv=%b sr=%b sr1=%b dv1=%b required 0 00 0 1 1 0",
               carry, sum, done_valid, start_ready, sr1, dv1);
    end
    clk_run = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_basic_add();
    int lat; logic [7:0] s; logic c; logic [8:0] e;
    drive_op(8'h5A, 8'h3C, 1'b0, lat, s, c);
    e = sb.pop_front(); last_exp = e;
    n_cmp++;
    if (lat !== 8) begin
      n_err++; $display("FAIL basic_latency: got %0d required 8", lat);
    end
    n_cmp++;
    if ({c, s} !== e || e !== 9'h096) begin
      n_err++; $display("FAIL basic_result: got %b_%h required %b_%h", c, s, e[8], e[7:0]);
    end
    n_cmp++;
    if (start_ready !== 1'b1) begin
      n_err++; $display("FAIL basic_idle_return: got start_ready=%b required 1", start_ready);
    end
  endtask

  task automatic test_carry();
    logic [7:0] ta[3] = '{8'hFF, 8'hFF, 8'h00};
    logic [7:0] tb[3] = '{8'h01, 8'hFF, 8'h00};
    logic       tc[3] = '{1'b0, 1'b1, 1'b1};
    int lat; logic [7:0] s; logic c; logic [8:0] e;
    for (int k = 0; k < 3; k++) begin
      drive_op(ta[k], tb[k], tc[k], lat, s, c);
      e = sb.pop_front(); last_exp = e;
      n_cmp++;
      if ({c, s} !== e || lat !== 8) begin
        n_err++;
        $display("FAIL carry_%0d: got %b_%h lat=%0d required %b_%h lat=8", k, c, s, lat, e[8], e[7:0]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [8:0] e; logic [7:0] s; logic c; int lat;
    a = 8'hA7; b = 8'h6E; c_in = 1'b1; start_valid = 1'b1; done_ready = 1'b0;
    sb.push_back(9'h0A7 + 9'h06E + 9'h001);
    @(posedge clk); #1;
    lat = 999;
    for (int i = 1; i <= 40; i++) begin
      a = 8'($urandom); b = 8'($urandom); c_in = 1'($urandom);
      @(posedge clk); #1;
      if (done_valid) begin
        lat = i;
        break;
      end
      n_cmp++;
      if ({carry, sum} !== last_exp || start_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_run_hold: got %b_%h sr=%b required %b_%h sr=0",
                 carry, sum, start_ready, last_exp[8], last_exp[7:0]);
      end
    end
    e = sb.pop_front();
    s = sum; c = carry;
    n_cmp++;
    if ({c, s} !== e || lat !== 8) begin
      n_err++; $display("FAIL bp_result: got %b_%h lat=%0d required %b_%h lat=8", c, s, lat, e[8], e[7:0]);
    end
    for (int i = 0; i < 5; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      @(posedge clk); #1;
      n_cmp++;
      if ({carry, sum} !== e || done_valid !== 1'b1 || start_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_stall_%0d: got %b_%h dv=%b sr=%b required %b_%h dv=1 sr=0",
                 i, carry, sum, done_valid, start_ready, e[8], e[7:0]);
      end
    end
    done_ready = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0; done_ready = 1'b0;
    last_exp = e;
    n_cmp++;
    if (done_valid !== 1'b0 || start_ready !== 1'b1 || {carry, sum} !== e) begin
      n_err++;
      $display("FAIL bp_release: got dv=%b sr=%b %b_%h required dv=0 sr=1 %b_%h",
               done_valid, start_ready, carry, sum, e[8], e[7:0]);
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [7:0] s; logic c; logic [8:0] e;
    a = 8'h12; b = 8'h34; c_in = 1'b0; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({carry, sum, done_valid, start_ready} !== {1'b0, 8'h00, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_mid: got carry=%b sum=%h dv=%b sr=%b required 0 00 0 1",
               carry, sum, done_valid, start_ready);
    end
    @(posedge clk); #1 rst = 1'b0;
    drive_op(8'h01, 8'h02, 1'b0, lat, s, c);
    e = sb.pop_front(); last_exp = e;
    n_cmp++;
    if ({c, s} !== e || e !== 9'h003 || lat !== 8) begin
      n_err++; $display("FAIL reset_mid_rerun: got %b_%h lat=%0d required 0_03 lat=8", c, s, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ta[3] = '{8'h11, 8'hF0, 8'h80};
    logic [7:0] tb[3] = '{8'h22, 8'h0F, 8'h80};
    logic       tc[3] = '{1'b0, 1'b1, 1'b0};
    int idx = 0; int done_cnt = 0; int last_acc = -1;
    logic acc_now; logic [8:0] e;
    a = ta[0]; b = tb[0]; c_in = tc[0]; start_valid = 1'b1; done_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && done_cnt < 3; cyc++) begin
      acc_now = start_ready && start_valid;
      if (done_valid) begin
        e = sb.pop_front();
        done_cnt++;
        n_cmp++;
        if ({carry, sum} !== e) begin
          n_err++; $display("FAIL b2b_result_%0d: got %b_%h required %b_%h", done_cnt, carry, sum, e[8], e[7:0]);
        end
      end
      if (acc_now) begin
        sb.push_back({1'b0, a} + {1'b0, b} + {8'h00, c_in});
        if (last_acc >= 0) begin
          n_cmp++;
          if (cyc - last_acc != 10) begin
            n_err++; $display("FAIL b2b_interval: got %0d required 10", cyc - last_acc);
          end
        end
        last_acc = cyc;
        idx++;
      end
      @(posedge clk); #1;
      if (acc_now) begin
        if (idx < 3) begin
          a = ta[idx]; b = tb[idx]; c_in = tc[idx];
        end else begin
          start_valid = 1'b0;
        end
      end
    end
    start_valid = 1'b0; done_ready = 1'b0;
    n_cmp++;
    if (done_cnt != 3) begin
      n_err++; $display("FAIL b2b_timeout: got %0d results required 3", done_cnt);
    end
  endtask

  task automatic test_width1();
    logic [1:0] e;
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; sv1 = 1'b1;
    sb1.push_back(2'd1 + 2'd1 + 2'd1);
    @(posedge clk); #1;
    sv1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    n_cmp++;
    if (dv1 !== 1'b0 || sr1 !== 1'b0) begin
      n_err++; $display("FAIL w1_run: got dv=%b sr=%b required dv=0 sr=0", dv1, sr1);
    end
    @(posedge clk); #1;
    e = sb1.pop_front();
    n_cmp++;
    if (dv1 !== 1'b1 || {carry1, sum1} !== e) begin
      n_err++; $display("FAIL w1_result: got dv=%b %b_%b required dv=1 %b_%b", dv1, carry1, sum1, e[1], e[0]);
    end
    dr1 = 1'b1;
    @(posedge clk); #1;
    dr1 = 1'b0;
    n_cmp++;
    if (sr1 !== 1'b1 || dv1 !== 1'b0) begin
      n_err++; $display("FAIL w1_release: got sr=%b dv=%b required sr=1 dv=0", sr1, dv1);
    end
  endtask

  initial begin
    test_reset();
    @(posedge clk); #1;
    test_basic_add();
    test_carry();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_width1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial addition controller that sequences a single `full_adder` instance over two WIDTH-bit operands, one bit per clock, LSB first. A registered carry feeds each bit's carry back into the adder. Valid/ready handshakes on both sides let upstream logic, such as neighbour-count accumulation, share one adder cell instead of a WIDTH-bit ripple adder.

## Interface

**Parameters**
- WIDTH, 8, operand and result width in bits; legal range WIDTH >= 1.

**Ports**
- CLK  input  1  sole clock; all state changes on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- START_VALID  input  1  operands A, B and C_IN are valid.
- START_READY  output  1  controller can accept operands; high only in IDLE.
- A  input  WIDTH  addend; sampled only on the start-handshake edge.
- B  input  WIDTH  addend; sampled only on the start-handshake edge.
- C_IN  input  1  carry-in; sampled only on the start-handshake edge.
- SUM  output  WIDTH  registered result (A + B + C_IN) mod 2^WIDTH.
- CARRY  output  1  registered carry-out of bit WIDTH-1.
- DONE_VALID  output  1  SUM and CARRY hold a new result.
- DONE_READY  input  1  consumer accepts the result.

## Operation

**Internal state**
- Operand shift registers for A and B.
- Partial-sum shift register.
- Carry flop.
- Bit counter, `$clog2(WIDTH+1)` bits wide.
- FSM with states IDLE, RUN, DONE.
- Exactly one `full_adder` instance, with inputs A = A_sr[0], B = B_sr[0], C_IN = carry flop.

**IDLE**
- START_READY = 1 and DONE_VALID = 0.
- On START_VALID && START_READY:
  - load A, B into the shift registers;
  - carry flop <= C_IN;
  - counter <= 0;
  - go to RUN.

**RUN**
- START_READY = 0 and DONE_VALID = 0.
- Each edge:
  - the partial-sum register shifts right, with the adder's SUM entering at the MSB;
  - carry flop <= adder CARRY;
  - both operand registers shift right by 1;
  - counter increments.
- On the edge where counter == WIDTH-1:
  - SUM <= final partial sum, including the bit computed this cycle;
  - CARRY <= adder CARRY;
  - go to DONE.

**DONE**
- DONE_VALID = 1 and START_READY = 0.
- SUM and CARRY stay stable while DONE_READY is low.
- On DONE_VALID && DONE_READY, go to IDLE.

**Output and input rules**
- SUM and CARRY change only on DONE entry and on reset. They keep the last result through IDLE and RUN.
- Changes on A, B and C_IN outside the start-handshake edge have no effect.
- START_VALID is ignored outside IDLE.
- No carry is lost: CARRY is the true bit WIDTH of A + B + C_IN.

**Reset**
- Asserting RESET at any time, including mid-RUN or in DONE, immediately sets:
  - state = IDLE;
  - SUM = 0, CARRY = 0, DONE_VALID = 0, START_READY = 1;
  - all internal registers to 0.
- Partial results are discarded.
- Operation resumes on the first rising CLK edge after RESET deasserts.

## Timing

- **Start handshake:** on edge E0 (START_VALID && START_READY), the FSM enters RUN.
- **Bit processing:** edges E1..E_WIDTH process bits 0..WIDTH-1. DONE_VALID rises after E_WIDTH, i.e. WIDTH cycles after the accept edge.
- **Result handshake:** on edge E_WIDTH+k (k >= 1, first cycle with DONE_READY high), the FSM returns to IDLE. START_READY rises after that edge.
- **Throughput:** minimum initiation interval is WIDTH+2 cycles (accept, WIDTH RUN cycles, 1 DONE cycle). Start does not overlap with DONE.
- **WIDTH = 1:** RUN lasts one cycle; DONE_VALID rises after E1.
- **Combinational paths:** none from inputs to outputs. START_READY and DONE_VALID decode directly from the state register.

## Test plan

1. **Reset values.** Assert RESET with no clock running. Required: SUM=0x00, CARRY=0, DONE_VALID=0, START_READY=1, asynchronously and without waiting for a CLK edge.
2. **Basic add (WIDTH=8).** A=0x5A, B=0x3C, C_IN=0, one-cycle start pulse. Required: DONE_VALID high exactly 8 edges after the accept edge, SUM=0x96, CARRY=0.
3. **Carry propagation.**
   - A=0xFF, B=0x01, C_IN=0 -> SUM=0x00, CARRY=1.
   - A=0xFF, B=0xFF, C_IN=1 -> SUM=0xFF, CARRY=1.
   - A=0x00, B=0x00, C_IN=1 -> SUM=0x01, CARRY=0.
4. **Backpressure.**
   - Stimulus: DONE_READY held low for 5 cycles in DONE; during RUN and DONE, drive START_VALID=1 with A/B toggling randomly.
   - Required: SUM, CARRY and DONE_VALID stable; START_READY=0; the result matches the operands captured at accept; IDLE is entered on the first edge with DONE_READY=1.
5. **Reset mid-operation.** Assert RESET after the 3rd RUN edge of A=0x12, B=0x34. Required: immediate return to reset values. A following A=0x01, B=0x02 run yields SUM=0x03, CARRY=0 with normal 8-cycle latency.
6. **Back-to-back and WIDTH=1.**
   - Stimulus: START_VALID and DONE_READY held high continuously.
   - Required: accepts spaced every 10 cycles (WIDTH+2) with correct results.
   - A WIDTH=1 instance with A=1, B=1, C_IN=1 gives SUM=1, CARRY=1 with DONE_VALID 1 edge after accept.
